// File: rtl/instruction_cache_pkg.sv
// Shared types and field widths for the direct-mapped instruction cache.
// The FSM encoding is fixed so that debug probes and checkers can decode it.
package instruction_cache_pkg;
   localparam int TAG_W    = 3;
   localparam int INDEX_W  = 3;
   localparam int OFFSET_W = 2;
   localparam int BLOCK_W  = 128;
   localparam int NUM_SETS = 8;
   localparam int ADDR_W   = TAG_W + INDEX_W;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_READ = 2'd1,
      UPDATE   = 2'd2
   } state_t;
endpackage

// File: rtl/instruction_cache_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// Handshake: a memory request is open while mem_read=1; mem_address is stable for its
// whole life, and the block is transferred in the cycle where mem_read=1 and mem_busywait=0.
interface instruction_cache_if;
   import instruction_cache_pkg::*;

   logic [31:0]        pc;
   logic               fetch_en;
   logic [31:0]        instruction;
   logic               busywait;
   logic               mem_read;
   logic [ADDR_W-1:0]  mem_address;
   logic [BLOCK_W-1:0] mem_readinst;
   logic               mem_busywait;

   // master: the IF stage plus instruction memory; slave: the cache itself
   modport master (
      output pc, fetch_en, mem_readinst, mem_busywait,
      input  instruction, busywait, mem_read, mem_address
   );

   modport slave (
      input  pc, fetch_en, mem_readinst, mem_busywait,
      output instruction, busywait, mem_read, mem_address
   );
endinterface

// File: rtl/icache_word_select.sv
// Picks one 32-bit instruction out of a 128-bit cache block by word offset.
module icache_word_select
   import instruction_cache_pkg::*;
(
   input  logic [BLOCK_W-1:0]  line_data,
   input  logic [OFFSET_W-1:0] word_offset,
   output logic [31:0]         selected
);
   always_comb begin
      selected = line_data[31:0];
      case (word_offset)
         2'd0: selected = line_data[31:0];
         2'd1: selected = line_data[63:32];
         2'd2: selected = line_data[95:64];
         2'd3: selected = line_data[127:96];
         default: selected = line_data[31:0];
      endcase
   end
endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 8 lines of 128 bits, combinational hits,
// and a miss FSM that fetches one whole block from instruction memory.
module instruction_cache
   import instruction_cache_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   instruction_cache_if.slave  bus,
   output state_t              debug_state
);
   logic [NUM_SETS-1:0] valid;
   logic [TAG_W-1:0]    tag_array  [NUM_SETS];
   logic [BLOCK_W-1:0]  data_array [NUM_SETS];

   state_t              state;
   logic                mem_read_q;
   logic [ADDR_W-1:0]   mem_address_q;
   logic [ADDR_W-1:0]   fill_addr;
   logic [BLOCK_W-1:0]  fill_q;

   logic [TAG_W-1:0]    tag;
   logic [INDEX_W-1:0]  index;
   logic [OFFSET_W-1:0] offset;
   logic                hit;
   logic [31:0]         sel_word;
   logic                unused_pc;

   assign offset    = bus.pc[3:2];
   assign index     = bus.pc[6:4];
   assign tag       = bus.pc[9:7];
   assign unused_pc = ^{bus.pc[31:10], bus.pc[1:0]};

   // Reset gates the lookup so a stale valid bit cannot hit during the reset cycle.
   assign hit = bus.fetch_en & ~reset & valid[index] & (tag_array[index] == tag);

   icache_word_select u_word_select (
      .line_data   (data_array[index]),
      .word_offset (offset),
      .selected    (sel_word)
   );

   assign bus.instruction = hit ? sel_word : NOP_INSTR;
   assign bus.busywait    = bus.fetch_en & ~hit;
   assign bus.mem_read    = mem_read_q & ~reset;
   assign bus.mem_address = reset ? '0 : mem_address_q;
   assign debug_state     = state;

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= IDLE;
         valid         <= '0;
         mem_read_q    <= 1'b0;
         mem_address_q <= '0;
         fill_addr     <= '0;
         fill_q        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.fetch_en && !hit) begin
                  state         <= MEM_READ;
                  fill_addr     <= {tag, index};
                  mem_read_q    <= 1'b1;
                  mem_address_q <= {tag, index};
               end
            end
            MEM_READ: begin
               if (!bus.mem_busywait) begin
                  state         <= UPDATE;
                  fill_q        <= bus.mem_readinst;
                  mem_read_q    <= 1'b0;
                  mem_address_q <= '0;
               end
            end
            UPDATE: begin
               // The line written is the latched miss, not whatever the PC now points at.
               valid[fill_addr[INDEX_W-1:0]] <= 1'b1;
               state                         <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && state == UPDATE) begin
         tag_array[fill_addr[INDEX_W-1:0]]  <= fill_addr[ADDR_W-1:INDEX_W];
         data_array[fill_addr[INDEX_W-1:0]] <= fill_q;
      end
   end
endmodule

// File: tb/tb_instruction_cache.sv
// Bench for instruction_cache: directed scenarios then random traffic, all checked
// against a line-level reference model and a queue of expected memory requests.
module tb_instruction_cache;
   import instruction_cache_pkg::*;

   logic   clock = 1'b0;
   logic   reset;
   state_t debug_state;

   instruction_cache_if bus ();

   instruction_cache dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus.slave),
      .debug_state (debug_state)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;

   logic [127:0] mem_blocks [64];

   // reference model: which block each line holds, and the miss in flight
   bit          model_valid [8];
   logic [2:0]  model_tag   [8];
   bit          in_fill;
   bit          updating;
   logic [5:0]  fill_addr;
   logic [5:0]  exp_q [$];
   logic [5:0]  seen_reqs [$];

   int          wait_cnt;
   int          cur_lat;
   int          next_lat;
   bit          prev_mem_read;
   logic        last_busy;
   logic        last_mem_read;
   logic [31:0] last_instr;
   state_t      last_state;
   logic [5:0]  last_req;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_of(input logic [127:0] blk, input logic [1:0] off);
      return blk[off*32 +: 32];
   endfunction

   task automatic cycle();
      logic [2:0]  t;
      logic [2:0]  idx;
      logic [1:0]  off;
      bit          exp_hit;
      bit          exp_req;
      logic [31:0] exp_instr;
      @(negedge clock);
      t   = bus.pc[9:7];
      idx = bus.pc[6:4];
      off = bus.pc[3:2];
      exp_hit   = !reset && bus.fetch_en && model_valid[idx] && (model_tag[idx] == t);
      exp_instr = exp_hit ? word_of(mem_blocks[{t, idx}], off) : NOP_INSTR;
      exp_req   = !reset && in_fill && !updating;
      check("busywait", 32'(bus.busywait), 32'(bus.fetch_en && !exp_hit));
      check("instruction", bus.instruction, exp_instr);
      check("mem_read", 32'(bus.mem_read), 32'(exp_req));
      check("mem_address", 32'(bus.mem_address), exp_req ? 32'(fill_addr) : 32'd0);
      if (bus.mem_read && !prev_mem_read) begin
         check("req_pending", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) check("req_addr", 32'(bus.mem_address), 32'(exp_q.pop_front()));
         last_req = bus.mem_address;
         seen_reqs.push_back(bus.mem_address);
      end
      prev_mem_read = bus.mem_read;
      last_busy     = bus.busywait;
      last_mem_read = bus.mem_read;
      last_instr    = bus.instruction;
      last_state    = debug_state;
      // instruction memory: busy for cur_lat cycles of an open request, then delivers
      if (bus.mem_read) begin
         if (wait_cnt < cur_lat) begin
            bus.mem_busywait = 1'b1;
            bus.mem_readinst = {$urandom, $urandom, $urandom, $urandom};
            wait_cnt++;
         end else begin
            bus.mem_busywait = 1'b0;
            bus.mem_readinst = mem_blocks[bus.mem_address];
         end
      end else begin
         wait_cnt         = 0;
         cur_lat          = next_lat;
         bus.mem_busywait = 1'($urandom_range(0, 1));
         bus.mem_readinst = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clock);
      if (reset) begin
         foreach (model_valid[i]) model_valid[i] = 1'b0;
         in_fill  = 1'b0;
         updating = 1'b0;
         exp_q.delete();
      end else if (!in_fill) begin
         if (bus.fetch_en && !exp_hit) begin
            in_fill   = 1'b1;
            updating  = 1'b0;
            fill_addr = {t, idx};
            exp_q.push_back({t, idx});
         end
      end else if (!updating) begin
         if (!bus.mem_busywait) updating = 1'b1;
      end else begin
         model_valid[fill_addr[2:0]] = 1'b1;
         model_tag[fill_addr[2:0]]   = fill_addr[5:3];
         in_fill  = 1'b0;
         updating = 1'b0;
      end
      #1;
   endtask

   // Runs cycles until the fetch stops stalling; stall = number of busy cycles.
   task automatic wait_hit(output int stall);
      stall = 0;
      cycle();
      while (last_busy && stall < 60) begin
         stall++;
         cycle();
      end
      check("wait_timeout", 32'(last_busy), 32'd0);
   endtask

   initial begin
      int          stall;
      logic [31:0] p;
      logic [31:0] hit_words [3];
      logic [31:0] hit_pcs [3];

      foreach (mem_blocks[i]) mem_blocks[i] = {$urandom, $urandom, $urandom, $urandom};
      mem_blocks[0] = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
      foreach (model_valid[i]) begin
         model_valid[i] = 1'b0;
         model_tag[i]   = '0;
      end
      in_fill = 1'b0; updating = 1'b0; fill_addr = '0;
      wait_cnt = 0; cur_lat = 5; next_lat = 5; prev_mem_read = 1'b0; last_req = '0;
      reset = 1'b1; bus.fetch_en = 1'b1; bus.pc = 32'h0;
      bus.mem_busywait = 1'b1; bus.mem_readinst = '0;

      // cold miss
      cycle();
      check("reset_busywait", 32'(last_busy), 32'd1);
      check("reset_instr", last_instr, NOP_INSTR);
      reset = 1'b0;
      wait_hit(stall);
      check("cold_stall", 32'(stall), 32'd8);
      check("cold_instr", last_instr, 32'h0302_0100);
      check("cold_req", 32'(last_req), 32'd0);

      // same-line hits
      hit_pcs   = '{32'h004, 32'h008, 32'h00C};
      hit_words = '{32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C};
      for (int i = 0; i < 3; i++) begin
         bus.pc = hit_pcs[i];
         cycle();
         check("line_hit_busy", 32'(last_busy), 32'd0);
         check("line_hit_instr", last_instr, hit_words[i]);
         check("line_hit_mem_read", 32'(last_mem_read), 32'd0);
      end

      // conflict miss on index 0
      next_lat = 2;
      bus.pc = 32'h080;
      wait_hit(stall);
      check("conflict_stall", 32'(stall), 32'd5);
      check("conflict_req", 32'(last_req), 32'd8);
      bus.pc = 32'h000;
      wait_hit(stall);
      check("refetch_stall", 32'(stall), 32'd5);
      check("refetch_req", 32'(last_req), 32'd0);

      // reset while in MEM_READ
      next_lat = 6;
      bus.pc = 32'h010;
      cycle();
      cycle();
      check("pre_reset_mem_read", 32'(last_mem_read), 32'd1);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      bus.pc = 32'h000;
      cycle();
      check("post_reset_state", 32'(last_state), 32'(IDLE));
      check("post_reset_mem_read", 32'(last_mem_read), 32'd0);
      check("post_reset_miss", 32'(last_busy), 32'd1);
      next_lat = 1;
      wait_hit(stall);
      check("post_reset_instr", last_instr, 32'h0302_0100);

      // fetch disabled
      bus.fetch_en = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.pc = $urandom;
         cycle();
         check("idle_busy", 32'(last_busy), 32'd0);
         check("idle_instr", last_instr, NOP_INSTR);
         check("idle_mem_read", 32'(last_mem_read), 32'd0);
      end

      // PC moves while the block request is open
      bus.fetch_en = 1'b1;
      next_lat = 4;
      seen_reqs.delete();
      bus.pc = 32'h020;
      cycle();
      cycle();
      bus.pc = 32'h030;
      wait_hit(stall);
      check("pc_change_reqs", 32'(seen_reqs.size()), 32'd2);
      if (seen_reqs.size() == 2) begin
         check("pc_change_first", 32'(seen_reqs[0]), 32'd2);
         check("pc_change_second", 32'(seen_reqs[1]), 32'd3);
      end

      // random traffic
      for (int i = 0; i < 400; i++) begin
         reset        = ($urandom_range(0, 49) == 0);
         bus.fetch_en = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 2) == 0) begin
            p      = $urandom;
            p[9:7] = 3'($urandom_range(0, 1));
            bus.pc = p;
         end
         next_lat = $urandom_range(0, 4);
         cycle();
      end
      reset = 1'b0;
      bus.fetch_en = 1'b0;
      repeat (12) cycle();
      check("requests_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
